text_console_writer: RTL



---
 rtl/console_pkg.sv | 27 ++
 rtl/text_console_writer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/console_pkg.sv
`default_nettype none
// ============================================================================
//  Module : console_pkg
//  Brief  : Shared state encoding, control codes and default geometry for
//           the text console writer.
//  Rev    : 1.0  initial release
// ============================================================================
package console_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE      = 2'd1,
        CLEAR_LINE = 2'd2,
        CLEAR_ALL  = 2'd3
    } state_t;

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;

    localparam int         DEF_COLS  = 60;
    localparam int         DEF_ROWS  = 17;
    localparam logic [7:0] DEF_BLANK = 8'h20;

endpackage
`default_nettype wire

// File: rtl/text_console_writer.sv
`default_nettype none
// ============================================================================
//  Module : text_console_writer
//  Brief  : Byte-stream front end for the text VRAM write port; decodes
//           control codes, tracks the cursor and performs screen/line clears.
//  Rev    : 1.0  initial release
// ============================================================================
module text_console_writer
    import console_pkg::*;
#(
    parameter int         COLS       = DEF_COLS,
    parameter int         ROWS       = DEF_ROWS,
    parameter logic [7:0] BLANK      = DEF_BLANK,
    parameter int         VRAM_DEPTH = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [9:0] v_ada,
    output logic [7:0] v_din,
    output logic       v_cea,
    output logic [5:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy
);

    generate
        if (COLS * ROWS > VRAM_DEPTH) begin : g_geom_check
            $error("text_console_writer: COLS*ROWS exceeds VRAM_DEPTH");
        end
    endgenerate

    localparam logic [9:0] c_cols_10   = 10'(COLS);
    localparam logic [9:0] c_line_last = 10'(COLS - 1);
    localparam logic [9:0] c_vram_last = 10'(VRAM_DEPTH - 1);
    localparam logic [5:0] c_col_last  = 6'(COLS - 1);
    localparam logic [4:0] c_row_last  = 5'(ROWS - 1);

    state_t     r_state;
    logic [9:0] r_fill;
    logic [5:0] r_col;
    logic [4:0] r_row;
    logic       r_cea;
    logic [9:0] r_ada;
    logic [7:0] r_din;
    logic       r_ready;
    logic       r_busy;
    logic       r_adv;

    logic [4:0] w_next_row;
    logic [9:0] w_row_base;
    logic [9:0] w_next_base;

    assign w_next_row  = (r_row == c_row_last) ? 5'd0 : r_row + 5'd1;
    assign w_row_base  = 10'(r_row) * c_cols_10;
    assign w_next_base = 10'(w_next_row) * c_cols_10;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ALL;
            r_fill  <= 10'd0;
            r_col   <= 6'd0;
            r_row   <= 5'd0;
            r_cea   <= 1'b0;
            r_ada   <= 10'd0;
            r_din   <= 8'd0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_adv   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_ready) begin
                        case (in_data)
                            CH_CR: r_col <= 6'd0;
                            CH_LF: begin
                                r_col   <= 6'd0;
                                r_row   <= w_next_row;
                                r_state <= CLEAR_LINE;
                                r_fill  <= 10'd0;
                                r_cea   <= 1'b1;
                                r_ada   <= w_next_base;
                                r_din   <= BLANK;
                                r_ready <= 1'b0;
                                r_busy  <= 1'b1;
                            end
                            CH_BS: begin
                                // Erase happens at the already-decremented position.
                                if (r_col != 6'd0) begin
                                    r_col   <= r_col - 6'd1;
                                    r_state <= WRITE;
                                    r_cea   <= 1'b1;
                                    r_ada   <= w_row_base + 10'(r_col) - 10'd1;
                                    r_din   <= BLANK;
                                    r_ready <= 1'b0;
                                    r_adv   <= 1'b0;
                                end
                            end
                            CH_FF: begin
                                r_col   <= 6'd0;
                                r_row   <= 5'd0;
                                r_state <= CLEAR_ALL;
                                r_fill  <= 10'd0;
                                r_cea   <= 1'b1;
                                r_ada   <= 10'd0;
                                r_din   <= BLANK;
                                r_ready <= 1'b0;
                                r_busy  <= 1'b1;
                            end
                            default: begin
                                r_state <= WRITE;
                                r_cea   <= 1'b1;
                                r_ada   <= w_row_base + 10'(r_col);
                                r_din   <= in_data;
                                r_ready <= 1'b0;
                                r_adv   <= 1'b1;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    if (r_adv && (r_col == c_col_last)) begin
                        r_col   <= 6'd0;
                        r_row   <= w_next_row;
                        r_state <= CLEAR_LINE;
                        r_fill  <= 10'd0;
                        r_ada   <= w_next_base;
                        r_din   <= BLANK;
                        r_busy  <= 1'b1;
                    end else begin
                        if (r_adv) r_col <= r_col + 6'd1;
                        r_state <= IDLE;
                        r_cea   <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                CLEAR_LINE: begin
                    if (r_fill == c_line_last) begin
                        r_state <= IDLE;
                        r_cea   <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_fill <= r_fill + 10'd1;
                        r_ada  <= r_ada + 10'd1;
                    end
                end
                CLEAR_ALL: begin
                    // Coming out of reset the pulse train is not yet running; start it at 0.
                    if (!r_cea) begin
                        r_cea  <= 1'b1;
                        r_ada  <= 10'd0;
                        r_fill <= 10'd0;
                        r_din  <= BLANK;
                    end else if (r_fill == c_vram_last) begin
                        r_state <= IDLE;
                        r_cea   <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_fill <= r_fill + 10'd1;
                        r_ada  <= r_ada + 10'd1;
                    end
                end
                default: begin
                    r_state <= CLEAR_ALL;
                    r_fill  <= 10'd0;
                    r_cea   <= 1'b0;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = r_ready;
    assign v_ada      = r_ada;
    assign v_din      = r_din;
    assign v_cea      = r_cea;
    assign cursor_col = r_col;
    assign cursor_row = r_row;
    assign busy       = r_busy;

endmodule
`default_nettype wire
